// File: rtl/frame_sequencer.sv
// Per-frame scheduler: PHYS_STEPS physics substeps, one environment pass, then a commit.
// Optional watchdog on the wait states is enabled by defining FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer #(
    parameter int PHYS_STEPS     = 2,
    parameter int CNT_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            new_frame_in,
    output logic                            phys_start_out,
    input  logic                            phys_done_in,
    output logic                            env_start_out,
    input  logic                            env_done_in,
    output logic                            commit_out,
    output logic                            busy_out,
    output logic [$clog2(PHYS_STEPS+1)-1:0] step_idx_out,
    output logic [CNT_BITS-1:0]             overrun_count_out,
    output logic                            timeout_out
);
    // state        | meaning
    // S_IDLE       | waiting for a new-frame pulse
    // S_PHYS_START | phys_start pulse for substep step_idx
    // S_PHYS_WAIT  | waiting for phys_done
    // S_ENV_START  | env_start pulse
    // S_ENV_WAIT   | waiting for env_done
    // S_COMMIT     | commit pulse, back to idle next cycle

    localparam int IDX_W = $clog2(PHYS_STEPS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHYS_STEPS - 1);

    if (PHYS_STEPS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("frame_sequencer: PHYS_STEPS and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PHYS_START,
        S_PHYS_WAIT,
        S_ENV_START,
        S_ENV_WAIT,
        S_COMMIT
    } state_t;

    state_t               state_q;
    logic                 phys_start_q;
    logic                 env_start_q;
    logic                 commit_q;
    logic                 busy_q;
    logic [IDX_W-1:0]     step_idx_q;
    logic [CNT_BITS-1:0]  overrun_q;
    logic [CNT_BITS-1:0]  overrun_d;

    assign overrun_d = (&overrun_q) ? overrun_q : overrun_q + 1'b1;

`ifdef FRAME_SEQ_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
    logic            wd_expired;

    assign wd_expired  = (wd_q == '0);
    assign timeout_out = timeout_q;
`else
    assign timeout_out = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            phys_start_q <= 1'b0;
            env_start_q  <= 1'b0;
            commit_q     <= 1'b0;
            busy_q       <= 1'b0;
            step_idx_q   <= '0;
            overrun_q    <= '0;
`ifdef FRAME_SEQ_WATCHDOG_EN
            wd_q         <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            phys_start_q <= 1'b0;
            env_start_q  <= 1'b0;
            commit_q     <= 1'b0;

            // Frames arriving mid-sequence are dropped, only counted.
            if (new_frame_in && state_q != S_IDLE)
                overrun_q <= overrun_d;

            case (state_q)
                S_IDLE: begin
                    if (new_frame_in) begin
                        state_q      <= S_PHYS_START;
                        phys_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        step_idx_q   <= '0;
                    end
                end
                S_PHYS_START: begin
                    state_q <= S_PHYS_WAIT;
`ifdef FRAME_SEQ_WATCHDOG_EN
                    wd_q    <= WD_LOAD;
`endif
                end
                S_PHYS_WAIT: begin
                    if (phys_done_in) begin
                        if (step_idx_q < LAST_IDX) begin
                            step_idx_q   <= step_idx_q + 1'b1;
                            state_q      <= S_PHYS_START;
                            phys_start_q <= 1'b1;
                        end else begin
                            state_q     <= S_ENV_START;
                            env_start_q <= 1'b1;
                        end
                    end
`ifdef FRAME_SEQ_WATCHDOG_EN
                    else if (wd_expired) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q - 1'b1;
                    end
`endif
                end
                S_ENV_START: begin
                    state_q <= S_ENV_WAIT;
`ifdef FRAME_SEQ_WATCHDOG_EN
                    wd_q    <= WD_LOAD;
`endif
                end
                S_ENV_WAIT: begin
                    if (env_done_in) begin
                        state_q  <= S_COMMIT;
                        commit_q <= 1'b1;
                    end
`ifdef FRAME_SEQ_WATCHDOG_EN
                    else if (wd_expired) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q - 1'b1;
                    end
`endif
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign phys_start_out    = phys_start_q;
    assign env_start_out     = env_start_q;
    assign commit_out        = commit_q;
    assign busy_out          = busy_q;
    assign step_idx_out      = step_idx_q;
    assign overrun_count_out = overrun_q;

endmodule
